seq_det_prog: RTL and testbench
===============================

// Module: seq_det_prog
// PURPOSE
//   Runtime-programmable serial pattern detector; successor to the fixed "101" detector.
//   Matches a 1..MAX_LEN-bit pattern on a qualified serial bit stream.
//   Overlapping or non-overlapping detection is selectable at runtime.
//   Keeps a saturating match counter. Sits on the serial RX path, after bit recovery.
// PARAMETERS
//   MAX_LEN      8       maximum pattern length in bits (>=2)
//   CNT_W        8       width of match counter
//   DEF_PATTERN  'b101   reset pattern, right-aligned in MAX_LEN bits
//   DEF_LEN      3       reset pattern length
//   DEF_OVERLAP  1       reset overlap mode (1 = overlapping)
//   LEN_W        $clog2(MAX_LEN+1)  derived; do not override
// PORTS
//   clk          in   1        clock, rising edge
//   rst_n        in   1        asynchronous reset, active-low
//   cfg_we       in   1        load cfg_pattern/cfg_len/cfg_overlap this cycle
//   cfg_pattern  in   MAX_LEN  pattern, right-aligned; bit [len-1] = first bit received
//   cfg_len      in   LEN_W    pattern length, legal 1..MAX_LEN
//   cfg_overlap  in   1        1 = overlapping, 0 = non-overlapping
//   cfg_err      out  1        1-cycle pulse: rejected config write
//   in_valid     in   1        seq_in is valid this cycle
//   seq_in       in   1        serial data bit
//   clr_cnt      in   1        synchronous clear of match_cnt
//   detected     out  1        registered 1-cycle pulse per match
//   match_cnt    out  CNT_W    saturating match count
//   fill_out     out  LEN_W    debug: number of valid history bits (0..len)
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//       hist=0, fill=0, detected=0, cfg_err=0, match_cnt=0.
//       pattern/len/overlap return to DEF_* values.
//   - History update, on in_valid=1 with cfg_we=0:
//       hist <= {hist[MAX_LEN-2:0], seq_in}; fill <= min(fill+1, len).
//   - Match condition, evaluated on the updated history:
//       (fill+1 >= len) && (new_hist[len-1:0] == pattern[len-1:0]).
//       Bits above len are ignored.
//   - Latency: detected=1 in the cycle after the clock edge that sampled the last pattern bit.
//     detected is 0 in every other cycle. Never asserts without in_valid.
//   - Overlap=1: fill stays at len after a match, so suffix bits are reused.
//       Example: "101" on 1,0,1,0,1 gives 2 matches.
//   - Overlap=0: fill is forced to 0 after a match. The next match needs len fresh bits.
//   - in_valid=0 cycles: hist and fill hold; gaps never break a partial match.
//   - Config write, cfg_we=1:
//       Legal when 1 <= cfg_len <= MAX_LEN. Latches all three config fields and clears fill and hist.
//       In the same cycle detected=0 and the in_valid bit is dropped (cfg wins).
//       Illegal cfg_len (0 or >MAX_LEN): config, hist and fill unchanged; cfg_err=1 next cycle.
//   - match_cnt: +1 per match, saturating at 2^CNT_W-1 (no wrap).
//       clr_cnt alone -> 0.
//       clr_cnt coincident with a match -> 1 (clear, then count).
//       Unaffected by cfg_we.
//   - Implementation is a length-masked shift register plus fill counter, not a per-pattern FSM.
//     All outputs are registered.
// TESTING
//   1. Reset defaults, in_valid=1, bits 1,0,1,0,1
//        -> detected pulses after bits 3 and 5; match_cnt=2.
//   2. cfg pattern 'b101, len 3, overlap=0; bits 1,0,1,0,1
//        -> single pulse after bit 3; match_cnt=1; fill_out=0 after the match.
//   3. cfg pattern 8'hA5, len 8; bits 1,0,1,0,0,1,0,1 with random in_valid gaps
//        -> exactly one pulse, after bit 8; none earlier.
//   4. cfg_we with cfg_len=0, then cfg_len=MAX_LEN+1
//        -> cfg_err pulse each time; old config still detects "101".
//   5. CNT_W=4: 20 matches -> match_cnt holds at 15.
//      clr_cnt coincident with a match -> match_cnt=1.
//   6. rst_n low mid-pattern (after bits 1,0)
//        -> all outputs 0 immediately; defaults restored; next 1,0,1 -> one pulse.

Source files
------------

// File: rtl/seq_det_prog.sv
// seq_det_prog: runtime-programmable serial pattern detector with a saturating match counter.
// The detector is a length-masked shift register plus a fill counter, not a per-pattern FSM.
module seq_det_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b101),
  parameter int DEF_LEN = 3,
  parameter bit DEF_OVERLAP = 1'b1,
  localparam int LEN_W = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  input  logic               in_valid,
  input  logic               seq_in,
  input  logic               clr_cnt,
  output logic               detected,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [LEN_W-1:0]   fill_out
);
  logic [MAX_LEN-1:0] r_hist, r_pattern, w_hist, w_mask;
  logic [LEN_W-1:0]   r_len, r_fill, w_fill_nxt;
  logic [LEN_W:0]     w_fill_inc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_overlap, r_detected, r_cfg_err, w_cfg_ok, w_shift, w_match;
  // A length of MAX_LEN shifts the 1 out entirely, so the subtraction yields an all-ones mask.
  always_comb begin
    w_hist = {r_hist[MAX_LEN-2:0], seq_in};
    w_mask = (MAX_LEN'(1) << r_len) - MAX_LEN'(1);
    w_fill_inc = {1'b0, r_fill} + (LEN_W+1)'(1);
    w_cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    w_shift = in_valid && !cfg_we;
    w_match = w_shift && (w_fill_inc >= {1'b0, r_len}) && (((w_hist ^ r_pattern) & w_mask) == '0);
    w_fill_nxt = (w_match && !r_overlap) ? '0 : (r_fill < r_len) ? r_fill + LEN_W'(1) : r_len;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_detected <= 1'b0;
      r_cfg_err <= 1'b0;
      r_cnt <= '0;
      r_pattern <= DEF_PATTERN;
      r_len <= LEN_W'(DEF_LEN);
      r_overlap <= DEF_OVERLAP;
    end else begin
      r_detected <= w_match;
      r_cfg_err <= cfg_we && !w_cfg_ok;
      if (cfg_we && w_cfg_ok) begin
        r_pattern <= cfg_pattern;
        r_len <= cfg_len;
        r_overlap <= cfg_overlap;
        r_hist <= '0;
        r_fill <= '0;
      end else if (w_shift) begin
        r_hist <= w_hist;
        r_fill <= w_fill_nxt;
      end
      r_cnt <= clr_cnt ? CNT_W'(w_match) : (w_match && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end
  assign detected = r_detected;
  assign cfg_err = r_cfg_err;
  assign match_cnt = r_cnt;
  assign fill_out = r_fill;
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: table-driven and hand-sequenced checks of seq_det_prog with a 4-bit counter.
module tb_seq_det_prog;
  localparam int ML = 8;
  localparam int CW = 4;
  localparam int LW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_overlap = 1'b0, in_valid = 1'b0, seq_in = 1'b0, clr_cnt = 1'b0;
  logic [ML-1:0] cfg_pattern = '0;
  logic [LW-1:0] cfg_len = '0;
  logic cfg_err, detected;
  logic [CW-1:0] match_cnt;
  logic [LW-1:0] fill_out;
  always #5 clk = ~clk;
  seq_det_prog #(.MAX_LEN(ML), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cfg_err(cfg_err), .in_valid(in_valid), .seq_in(seq_in),
    .clr_cnt(clr_cnt), .detected(detected), .match_cnt(match_cnt), .fill_out(fill_out)
  );
  typedef struct {
    logic we; logic [ML-1:0] pat; logic [LW-1:0] len; logic ov, v, b, clr;
    logic det; logic [CW-1:0] cnt; logic err; logic [LW-1:0] fill;
  } vec_t;
  typedef struct {logic det; logic [CW-1:0] cnt; logic err; logic [LW-1:0] fill;} exp_t;
  exp_t exp_q[$];
  vec_t tbl[$];
  int n_vec = 0, n_bad = 0;
  function automatic vec_t mk(logic we, logic [ML-1:0] pat, logic [LW-1:0] len, logic ov, logic v,
                              logic b, logic clr, logic det, logic [CW-1:0] cnt, logic err, logic [LW-1:0] fill);
    vec_t t;
    t.we = we; t.pat = pat; t.len = len; t.ov = ov; t.v = v; t.b = b; t.clr = clr;
    t.det = det; t.cnt = cnt; t.err = err; t.fill = fill;
    return t;
  endfunction
  task automatic chk(string nm, int act, int exp);
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic apply(vec_t t, string nm);
    exp_t e;
    cfg_we = t.we; cfg_pattern = t.pat; cfg_len = t.len; cfg_overlap = t.ov;
    in_valid = t.v; seq_in = t.b; clr_cnt = t.clr;
    exp_q.push_back('{t.det, t.cnt, t.err, t.fill});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    chk({nm, ".detected"}, int'(detected), int'(e.det));
    chk({nm, ".match_cnt"}, int'(match_cnt), int'(e.cnt));
    chk({nm, ".cfg_err"}, int'(cfg_err), int'(e.err));
    chk({nm, ".fill_out"}, int'(fill_out), int'(e.fill));
    cfg_we = 1'b0; in_valid = 1'b0; clr_cnt = 1'b0;
  endtask
  task automatic bitv(logic v, logic b, logic det, logic [CW-1:0] cnt, logic [LW-1:0] fill, string nm);
    apply(mk(0, '0, '0, 0, v, b, 0, det, cnt, 0, fill), nm);
  endtask
  task automatic check_zero(string nm);
    n_vec++;
    chk({nm, ".detected"}, int'(detected), 0);
    chk({nm, ".match_cnt"}, int'(match_cnt), 0);
    chk({nm, ".cfg_err"}, int'(cfg_err), 0);
    chk({nm, ".fill_out"}, int'(fill_out), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    logic [ML-1:0] a5;
    // test 1: reset defaults ("101", overlapping)
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 0, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 1, 1, 0, 3));
    tbl.push_back(mk(0, '0, '0, 0, 1, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 1, 2, 0, 3));
    // test 2: non-overlapping "101"; cfg coincident with clr and a dropped valid bit
    tbl.push_back(mk(1, 8'b101, 3, 0, 1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, '0, '0, 0, 1, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, '0, '0, 0, 1, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, '0, '0, 0, 1, 1, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, '0, '0, 0, 0, 1, 0, 0, 1, 0, 2));
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));
    // test 3: 8-bit pattern A5 with random valid gaps
    a5 = 8'hA5;
    apply(mk(1, a5, 8, 1, 0, 0, 1, 0, 0, 0, 0), "t3.cfg");
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) bitv(0, ~a5[7-i], 0, 0, LW'(i), $sformatf("t3.gap%0d", i));
      bitv(1, a5[7-i], i == 7, CW'(i == 7), LW'(i + 1), $sformatf("t3.bit%0d", i));
    end
    bitv(0, 1, 0, 1, 8, "t3.after");
    // test 4: illegal lengths leave config, history and fill untouched
    apply(mk(1, 8'b101, 3, 1, 1, 1, 1, 0, 0, 0, 0), "t4.cfg");
    bitv(1, 1, 0, 0, 1, "t4.b1");
    apply(mk(1, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 1, 1), "t4.len0");
    bitv(0, 0, 0, 0, 1, "t4.idle");
    apply(mk(1, 8'h00, 9, 0, 1, 1, 0, 0, 0, 1, 1), "t4.len9");
    bitv(1, 0, 0, 0, 2, "t4.b2");
    bitv(1, 1, 1, 1, 3, "t4.b3");
    // test 5: length-1 pattern matches every 1; counter saturates, then clear-with-match
    apply(mk(1, 8'h01, 1, 1, 0, 0, 1, 0, 0, 0, 0), "t5.cfg");
    for (int k = 1; k <= 20; k++) bitv(1, 1, 1, CW'(k > 15 ? 15 : k), 1, $sformatf("t5.m%0d", k));
    bitv(1, 0, 0, 15, 1, "t5.zero");
    apply(mk(0, '0, '0, 0, 1, 1, 1, 1, 1, 0, 1), "t5.clr_match");
    apply(mk(0, '0, '0, 0, 0, 0, 1, 0, 0, 0, 1), "t5.clr_only");
    // test 6: async reset mid-pattern restores defaults
    apply(mk(1, 8'b011, 3, 0, 0, 0, 0, 0, 0, 0, 0), "t6.cfg");
    bitv(1, 0, 0, 0, 1, "t6.b0");
    bitv(1, 1, 0, 0, 2, "t6.b1");
    bitv(1, 1, 1, 1, 0, "t6.b2");
    bitv(1, 1, 0, 1, 1, "t6.b3");
    bitv(1, 0, 0, 1, 2, "t6.b4");
    #2 rst_n = 1'b0;
    #1 check_zero("t6.rst");
    @(posedge clk);
    #1 check_zero("t6.rst_hold");
    rst_n = 1'b1;
    bitv(1, 1, 0, 0, 1, "t6.d1");
    bitv(1, 0, 0, 0, 2, "t6.d2");
    bitv(1, 1, 1, 1, 3, "t6.d3");
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
